// File: rtl/intadd_rr_sched.sv
// Round-robin scheduler in front of a single saturating 32-bit integer adder.
// NREQ requesters share one output register. The output register takes a new result
// in the same cycle that it is drained.
module intadd_rr_sched #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*32-1:0]   req_src0,
    input  logic [NREQ*32-1:0]   req_src1,
    input  logic [NREQ*3-1:0]    req_sign,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_dst,
    output logic [IDW-1:0]       rsp_id,
    output logic                 rsp_sat,
    output logic [15:0]          op_cnt
);

    logic [IDW-1:0] ptr_q, ptr_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [31:0]    rsp_dst_q, rsp_dst_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;
    logic           rsp_sat_q, rsp_sat_d;
    logic [15:0]    op_cnt_q, op_cnt_d;

    logic           out_free;
    logic           grant_found;
    logic [IDW-1:0] grant_idx;
    logic [IDW-1:0] scan_idx;
    logic           transfer;

    logic [31:0]    sel_src0;
    logic [31:0]    sel_src1;
    logic [2:0]     sel_sign;
    logic           is_signed;
    logic [32:0]    src0_ext;
    logic [32:0]    src1_ext;
    logic [32:0]    sum33;
    logic [31:0]    sat_dst;
    logic           sat_flag;

    assign out_free = !rsp_valid_q || rsp_ready;

    // NREQ is a power of two, so IDW-bit wraparound gives the modulo-NREQ search order.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = ptr_q + IDW'(k);
            if (!grant_found && req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    assign transfer = grant_found && out_free && !rst;

    always_comb begin
        req_ready = '0;
        if (transfer) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        sel_src0 = '0;
        sel_src1 = '0;
        sel_sign = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (IDW'(i) == grant_idx) begin
                sel_src0 = req_src0[i*32 +: 32];
                sel_src1 = req_src1[i*32 +: 32];
                sel_sign = req_sign[i*3 +: 3];
            end
        end
    end

    // A single sign flag from any of the three bits turns the whole operation signed.
    always_comb begin
        is_signed = |sel_sign;
        src0_ext  = is_signed ? {sel_src0[31], sel_src0} : {1'b0, sel_src0};
        src1_ext  = is_signed ? {sel_src1[31], sel_src1} : {1'b0, sel_src1};
        sum33     = src0_ext + src1_ext;
        sat_dst   = sum33[31:0];
        sat_flag  = 1'b0;
        if (is_signed) begin
            if (sum33[32] && !sum33[31]) begin
                sat_dst  = 32'h8000_0000;
                sat_flag = 1'b1;
            end else if (!sum33[32] && sum33[31]) begin
                sat_dst  = 32'h7FFF_FFFF;
                sat_flag = 1'b1;
            end
        end else if (sum33[32]) begin
            sat_dst  = 32'hFFFF_FFFF;
            sat_flag = 1'b1;
        end
    end

    always_comb begin
        ptr_d       = ptr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dst_d   = rsp_dst_q;
        rsp_id_d    = rsp_id_q;
        rsp_sat_d   = rsp_sat_q;
        op_cnt_d    = op_cnt_q;
        if (transfer) begin
            ptr_d       = grant_idx + IDW'(1);
            rsp_valid_d = 1'b1;
            rsp_dst_d   = sat_dst;
            rsp_id_d    = grant_idx;
            rsp_sat_d   = sat_flag;
            op_cnt_d    = op_cnt_q + 16'd1;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dst_q   <= '0;
            rsp_id_q    <= '0;
            rsp_sat_q   <= 1'b0;
            op_cnt_q    <= '0;
        end else begin
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dst_q   <= rsp_dst_d;
            rsp_id_q    <= rsp_id_d;
            rsp_sat_q   <= rsp_sat_d;
            op_cnt_q    <= op_cnt_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_dst   = rsp_dst_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sat   = rsp_sat_q;
    assign op_cnt    = op_cnt_q;

endmodule

// File: tb/tb_intadd_rr_sched.sv
// Directed bench for intadd_rr_sched: saturation cases, round-robin order,
// backpressure, reset mid-operation and op_cnt wraparound.
module tb_intadd_rr_sched;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*32-1:0]  req_src0;
    logic [NREQ*32-1:0]  req_src1;
    logic [NREQ*3-1:0]   req_sign;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [31:0]         rsp_dst;
    logic [IDW-1:0]      rsp_id;
    logic                rsp_sat;
    logic [15:0]         op_cnt;

    int testsRun    = 0;
    int testsFailed = 0;

    intadd_rr_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_src0  (req_src0),
        .req_src1  (req_src1),
        .req_sign  (req_sign),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_dst   (rsp_dst),
        .rsp_id    (rsp_id),
        .rsp_sat   (rsp_sat),
        .op_cnt    (op_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setOperands(input int i, input logic [31:0] a, input logic [31:0] b,
                               input logic [2:0] s);
        req_src0[i*32 +: 32] = a;
        req_src1[i*32 +: 32] = b;
        req_sign[i*3 +: 3]   = s;
    endtask

    // Requester i adds (i+1)*0x1000 and (i+1), unsigned, giving a recognisable result.
    task automatic loadDefaults();
        for (int i = 0; i < NREQ; i++) begin
            setOperands(i, 32'((i + 1) * 4096), 32'(i + 1), 3'b000);
        end
    endtask

    function automatic logic [31:0] defaultSum(input int i);
        return 32'((i + 1) * 4096 + i + 1);
    endfunction

    task automatic applyStimulus(input logic r, input logic [NREQ-1:0] v, input logic rr);
        rst       = r;
        req_valid = v;
        rsp_ready = rr;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        req_src0  = '0;
        req_src1  = '0;
        req_sign  = '0;
        loadDefaults();

        applyStimulus(1'b1, 4'b1111, 1'b1);
        tick();
        tick();
        checkOutput("reset_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset_dst",   rsp_dst,        32'd0);
        checkOutput("reset_id",    32'(rsp_id),    32'd0);
        checkOutput("reset_sat",   32'(rsp_sat),   32'd0);
        checkOutput("reset_cnt",   32'(op_cnt),    32'd0);
        checkOutput("reset_ready", 32'(req_ready), 32'd0);

        // Round robin from ptr=0, starting in the first cycle after reset release.
        applyStimulus(1'b0, 4'b1111, 1'b1);
        for (int k = 0; k < 8; k++) begin
            checkOutput($sformatf("rr_ready%0d", k), 32'(req_ready), 32'(1 << (k % 4)));
            tick();
            checkOutput($sformatf("rr_id%0d", k),    32'(rsp_id),    32'(k % 4));
            checkOutput($sformatf("rr_dst%0d", k),   rsp_dst,        defaultSum(k % 4));
            checkOutput($sformatf("rr_valid%0d", k), 32'(rsp_valid), 32'd1);
            checkOutput($sformatf("rr_cnt%0d", k),   32'(op_cnt),    32'(k + 1));
        end

        applyStimulus(1'b0, 4'b0000, 1'b1);
        checkOutput("idle_ready", 32'(req_ready), 32'd0);
        tick();
        checkOutput("drain_valid", 32'(rsp_valid), 32'd0);
        checkOutput("drain_cnt",   32'(op_cnt),    32'd8);

        // Unsigned saturation on requester 0.
        setOperands(0, 32'hFFFF_FFF0, 32'h0000_0020, 3'b000);
        applyStimulus(1'b0, 4'b0001, 1'b1);
        checkOutput("usat_ready", 32'(req_ready), 32'b0001);
        tick();
        checkOutput("usat_dst", rsp_dst,        32'hFFFF_FFFF);
        checkOutput("usat_sat", 32'(rsp_sat),   32'd1);
        checkOutput("usat_id",  32'(rsp_id),    32'd0);
        checkOutput("usat_cnt", 32'(op_cnt),    32'd9);

        // Signed saturation sequence on requester 1, back to back.
        setOperands(1, 32'h7FFF_FFFF, 32'h0000_0001, 3'b001);
        applyStimulus(1'b0, 4'b0010, 1'b1);
        checkOutput("spos_ready", 32'(req_ready), 32'b0010);
        tick();
        checkOutput("spos_dst", rsp_dst,      32'h7FFF_FFFF);
        checkOutput("spos_sat", 32'(rsp_sat), 32'd1);
        checkOutput("spos_id",  32'(rsp_id),  32'd1);

        setOperands(1, 32'h8000_0000, 32'hFFFF_FFFF, 3'b100);
        applyStimulus(1'b0, 4'b0010, 1'b1);
        checkOutput("sneg_ready", 32'(req_ready), 32'b0010);
        tick();
        checkOutput("sneg_dst", rsp_dst,      32'h8000_0000);
        checkOutput("sneg_sat", 32'(rsp_sat), 32'd1);

        setOperands(1, 32'hFFFF_FFFE, 32'h0000_0005, 3'b010);
        applyStimulus(1'b0, 4'b0010, 1'b1);
        tick();
        checkOutput("snorm_dst", rsp_dst,      32'h0000_0003);
        checkOutput("snorm_sat", 32'(rsp_sat), 32'd0);
        checkOutput("snorm_cnt", 32'(op_cnt),  32'd12);

        // Backpressure: result 3 from requester 1 must hold while operands change.
        loadDefaults();
        applyStimulus(1'b0, 4'b1111, 1'b0);
        for (int c = 0; c < 5; c++) begin
            checkOutput($sformatf("bp_ready%0d", c), 32'(req_ready), 32'd0);
            checkOutput($sformatf("bp_dst%0d", c),   rsp_dst,        32'h0000_0003);
            checkOutput($sformatf("bp_id%0d", c),    32'(rsp_id),    32'd1);
            checkOutput($sformatf("bp_valid%0d", c), 32'(rsp_valid), 32'd1);
            tick();
        end
        checkOutput("bp_cnt", 32'(op_cnt), 32'd12);
        applyStimulus(1'b0, 4'b1111, 1'b1);
        checkOutput("bp_regrant", 32'(req_ready), 32'b0100);
        tick();
        checkOutput("bp_next_dst", rsp_dst,     defaultSum(2));
        checkOutput("bp_next_id",  32'(rsp_id), 32'd2);
        checkOutput("bp_next_cnt", 32'(op_cnt), 32'd13);

        // Reset while a response is pending; no grant during reset.
        applyStimulus(1'b1, 4'b1111, 1'b1);
        checkOutput("rst_ready", 32'(req_ready), 32'd0);
        tick();
        checkOutput("rst_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_cnt",   32'(op_cnt),    32'd0);
        checkOutput("rst_dst",   rsp_dst,        32'd0);
        checkOutput("rst_id",    32'(rsp_id),    32'd0);
        applyStimulus(1'b0, 4'b1100, 1'b1);
        checkOutput("post_rst_ready", 32'(req_ready), 32'b0100);
        tick();
        checkOutput("post_rst_id",  32'(rsp_id), 32'd2);
        checkOutput("post_rst_dst", rsp_dst,      defaultSum(2));
        checkOutput("post_rst_cnt", 32'(op_cnt),  32'd1);
        checkOutput("post_rst_next_ready", 32'(req_ready), 32'b1000);

        // Counter wraparound after 65536 transfers.
        applyStimulus(1'b1, 4'b0000, 1'b1);
        tick();
        applyStimulus(1'b0, 4'b1111, 1'b1);
        for (int n = 0; n < 65535; n++) begin
            tick();
        end
        checkOutput("wrap_cnt_max", 32'(op_cnt), 32'h0000_FFFF);
        tick();
        checkOutput("wrap_cnt_zero", 32'(op_cnt),    32'd0);
        checkOutput("wrap_valid",    32'(rsp_valid), 32'd1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
